// File: rtl/mem_stage_pkg.sv
//------------------------------------------------------------------------------
// Module  : mem_stage_pkg
// Brief   : Shared load/store opcodes and FSM state encoding for the MEM stage.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mem_stage_pkg;

  // ldSt_enable encoding; 2'b11 is reserved and behaves as LDST_NONE
  localparam logic [1:0] LDST_NONE  = 2'b00;
  localparam logic [1:0] LDST_LOAD  = 2'b01;
  localparam logic [1:0] LDST_STORE = 2'b10;

  // Stage controller states
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  // True for the two opcodes that need a memory transaction
  function automatic logic is_mem_op(input logic [1:0] op);
    return (op == LDST_LOAD) || (op == LDST_STORE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_timeout_counter.sv
//------------------------------------------------------------------------------
// Module  : mem_timeout_counter
// Brief   : Wait-cycle counter for a pending memory access; flags the last
//           cycle the stage is allowed to wait for mem_ack.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,     // asynchronous, active low
  input  logic clear,     // start of a new access
  input  logic inc,       // one more cycle spent waiting
  output logic terminal   // count has reached TIMEOUT_CYCLES-1
);

  localparam int             CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0]  TC = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  assign terminal = (r_count == TC);

  // Clear wins over increment; the count never wraps because the stage
  // aborts the access on the terminal cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (inc && !terminal) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
//------------------------------------------------------------------------------
// Module  : mem_stage
// Brief   : Pipeline MEM stage. Holds one instruction, performs an optional
//           load/store handshake with timeout, and registers the writeback.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_stage #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,               // asynchronous, active low
  input  logic        enable_mem,
  input  logic [15:0] alu_result,
  input  logic [15:0] dataReg,
  input  logic [1:0]  ldSt_enable,
  input  logic [2:0]  destReg_addr,
  input  logic        we,
  input  logic [1:0]  bp_input,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] wb_data,
  output logic [2:0]  destReg_addr_output,
  output logic        we_output,
  output logic [1:0]  bp_output,
  output logic        wb_valid,
  output logic        mem_err
);

  import mem_stage_pkg::*;

  state_t      r_state;
  state_t      w_state_next;

  logic [15:0] r_alu;
  logic [15:0] r_data;
  logic [1:0]  r_ldst;
  logic [2:0]  r_dest;
  logic        r_we;
  logic [1:0]  r_bp;
  logic        r_v;

  logic        w_in_access;
  logic        w_stall;
  logic        w_terminal;
  logic        w_timeout;
  logic        w_capture;
  logic        w_start_mem;
  logic        w_complete;

  assign w_in_access = (r_state == ST_ACCESS);
  assign w_stall     = w_in_access && !mem_ack;
  assign w_timeout   = w_stall && w_terminal;
  assign w_capture   = !w_stall;
  assign w_start_mem = w_capture && enable_mem && is_mem_op(ldSt_enable);
  // mem_ack only means something while an access is outstanding
  assign w_complete  = (!w_in_access && r_v) || (w_in_access && mem_ack);
  assign stall       = w_stall;

  mem_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clear    (w_start_mem),
    .inc      (w_stall),
    .terminal (w_terminal)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and memory-port drive; a timeout abandons the access, otherwise
  // every capture edge decides afresh whether the new instruction needs memory
  always_comb begin
    w_state_next = r_state;
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = 16'h0000;
    mem_wdata    = 16'h0000;
    if (w_timeout) begin
      w_state_next = ST_IDLE;
    end else if (w_capture) begin
      w_state_next = w_start_mem ? ST_ACCESS : ST_IDLE;
    end
    if (w_in_access) begin
      mem_req   = 1'b1;
      mem_wr    = (r_ldst == LDST_STORE);
      mem_addr  = r_alu;
      mem_wdata = r_data;
    end
  end

  // Stage register: loads whenever upstream is not held; a timeout empties it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v    <= 1'b0;
      r_alu  <= 16'h0000;
      r_data <= 16'h0000;
      r_ldst <= LDST_NONE;
      r_dest <= 3'd0;
      r_we   <= 1'b0;
      r_bp   <= 2'd0;
    end else if (w_timeout) begin
      r_v <= 1'b0;
    end else if (w_capture) begin
      r_v <= enable_mem;
      if (enable_mem) begin
        r_alu  <= alu_result;
        r_data <= dataReg;
        r_ldst <= ldSt_enable;
        r_dest <= destReg_addr;
        r_we   <= we;
        r_bp   <= bp_input;
      end
    end
  end

  // Writeback registers: data fields hold between completions, strobes pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_data             <= 16'h0000;
      destReg_addr_output <= 3'd0;
      bp_output           <= 2'd0;
      we_output           <= 1'b0;
      wb_valid            <= 1'b0;
    end else if (w_complete) begin
      wb_data             <= (r_ldst == LDST_LOAD) ? mem_rdata : r_alu;
      destReg_addr_output <= r_dest;
      bp_output           <= r_bp;
      we_output           <= r_we && (r_ldst != LDST_STORE);
      wb_valid            <= 1'b1;
    end else begin
      we_output           <= 1'b0;
      wb_valid            <= 1'b0;
    end
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_err <= 1'b0;
    end else if (w_timeout) begin
      mem_err <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
//------------------------------------------------------------------------------
// Module  : tb_mem_stage
// Brief   : Self-checking bench for mem_stage: directed vector table, timeout
//           and reset sequences, then randomized traffic against a model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_stage;

  import mem_stage_pkg::*;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable_mem = 1'b0;
  logic [15:0] alu_result = 16'h0000;
  logic [15:0] dataReg = 16'h0000;
  logic [1:0]  ldSt_enable = 2'b00;
  logic [2:0]  destReg_addr = 3'd0;
  logic        we = 1'b0;
  logic [1:0]  bp_input = 2'd0;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_ack = 1'b0;
  logic        stall, mem_req, mem_wr, we_output, wb_valid, mem_err;
  logic [15:0] mem_addr, mem_wdata, wb_data;
  logic [2:0]  destReg_addr_output;
  logic [1:0]  bp_output;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .enable_mem(enable_mem), .alu_result(alu_result),
    .dataReg(dataReg), .ldSt_enable(ldSt_enable), .destReg_addr(destReg_addr),
    .we(we), .bp_input(bp_input), .stall(stall), .mem_req(mem_req), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_data(wb_data), .destReg_addr_output(destReg_addr_output), .we_output(we_output),
    .bp_output(bp_output), .wb_valid(wb_valid), .mem_err(mem_err)
  );

  // {stall, req, wr, addr, wdata, wb_data, dest, we, bp, valid, err}
  function automatic logic [58:0] dut_vec();
    return {stall, mem_req, mem_wr, mem_addr, mem_wdata, wb_data,
            destReg_addr_output, we_output, bp_output, wb_valid, mem_err};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [15:0] alu, input logic [15:0] data,
                       input logic [1:0] op, input logic [2:0] dest, input logic w,
                       input logic [1:0] bp);
    enable_mem = en; alu_result = alu; dataReg = data; ldSt_enable = op;
    destReg_addr = dest; we = w; bp_input = bp;
  endtask

  typedef struct {
    logic en; logic [15:0] alu; logic [15:0] data; logic [1:0] op; logic [2:0] dest;
    logic w; logic [1:0] bp; logic ack; logic [15:0] rdata;
    logic e_stall; logic e_req; logic e_wr; logic [15:0] e_addr; logic [15:0] e_wdata;
    logic [15:0] e_wb; logic [2:0] e_dest; logic e_we; logic [1:0] e_bp; logic e_valid;
  } vec_t;

  vec_t tbl [14];

  // Reference model state: the instruction held by the stage and what it is doing
  typedef struct { logic [15:0] alu; logic [15:0] data; logic [1:0] op; logic [2:0] dest;
                   logic w; logic [1:0] bp; } instr_t;
  instr_t      p;
  logic        p_valid, m_busy, m_stall, m_valid, m_we, m_err, m_done, m_tmo;
  int          waited;
  logic [15:0] m_wb;
  logic [2:0]  m_dest;
  logic [1:0]  m_bp;
  logic [58:0] exp_v;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //                 en    alu       data      op     dest  we    bp    ack   rdata      stall req   wr    addr      wdata     wb        dest  we    bp    valid
    tbl[0]  = '{1'b1, 16'h1234, 16'h0000, 2'd0, 3'd3, 1'b1, 2'd1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{1'b0, 16'h0000, 16'h0000, 2'd0, 3'd0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 1'b0, 2'd0, 1'b0};
    tbl[2]  = '{1'b0, 16'h0000, 16'h0000, 2'd0, 3'd0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1234, 3'd3, 1'b1, 2'd1, 1'b1};
    tbl[3]  = '{1'b1, 16'h0040, 16'h1111, 2'd1, 3'd5, 1'b1, 2'd2, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1234, 3'd3, 1'b0, 2'd1, 1'b0};
    tbl[4]  = '{1'b1, 16'h7777, 16'h0000, 2'd0, 3'd6, 1'b1, 2'd3, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0040, 16'h1111, 16'h1234, 3'd3, 1'b0, 2'd1, 1'b0};
    tbl[5]  = '{1'b1, 16'h7777, 16'h0000, 2'd0, 3'd6, 1'b1, 2'd3, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0040, 16'h1111, 16'h1234, 3'd3, 1'b0, 2'd1, 1'b0};
    tbl[6]  = '{1'b1, 16'h7777, 16'h0000, 2'd0, 3'd6, 1'b1, 2'd3, 1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b0, 16'h0040, 16'h1111, 16'h1234, 3'd3, 1'b0, 2'd1, 1'b0};
    tbl[7]  = '{1'b1, 16'h0010, 16'h5A5A, 2'd2, 3'd7, 1'b1, 2'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hBEEF, 3'd5, 1'b1, 2'd2, 1'b1};
    tbl[8]  = '{1'b1, 16'h2222, 16'h0000, 2'd0, 3'd1, 1'b1, 2'd1, 1'b1, 16'hDEAD, 1'b0, 1'b1, 1'b1, 16'h0010, 16'h5A5A, 16'h7777, 3'd6, 1'b1, 2'd3, 1'b1};
    tbl[9]  = '{1'b0, 16'h0000, 16'h0000, 2'd0, 3'd0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0010, 3'd7, 1'b0, 2'd0, 1'b1};
    tbl[10] = '{1'b0, 16'h0000, 16'h0000, 2'd0, 3'd0, 1'b0, 2'd0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h2222, 3'd1, 1'b1, 2'd1, 1'b1};
    tbl[11] = '{1'b1, 16'h0ABC, 16'h0000, 2'd3, 3'd2, 1'b1, 2'd2, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h2222, 3'd1, 1'b0, 2'd1, 1'b0};
    tbl[12] = '{1'b0, 16'h0000, 16'h0000, 2'd0, 3'd0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h2222, 3'd1, 1'b0, 2'd1, 1'b0};
    tbl[13] = '{1'b0, 16'h0000, 16'h0000, 2'd0, 3'd0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0ABC, 3'd2, 1'b1, 2'd2, 1'b1};

    // Reset state
    #1;
    check("reset outputs", 64'(dut_vec()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Directed vector table: ALU op, bubble, load with wait, store with first-cycle ack
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].en, tbl[i].alu, tbl[i].data, tbl[i].op, tbl[i].dest, tbl[i].w, tbl[i].bp);
      mem_ack = tbl[i].ack;
      mem_rdata = tbl[i].rdata;
      @(negedge clk);
      exp_v = {tbl[i].e_stall, tbl[i].e_req, tbl[i].e_wr, tbl[i].e_addr, tbl[i].e_wdata,
               tbl[i].e_wb, tbl[i].e_dest, tbl[i].e_we, tbl[i].e_bp, tbl[i].e_valid, 1'b0};
      check($sformatf("table row %0d", i), 64'(dut_vec()), 64'(exp_v));
      step();
    end
    mem_ack = 1'b0;

    // Ack arriving in the last allowed wait cycle completes normally
    drive(1'b1, 16'h0200, 16'h0000, LDST_LOAD, 3'd4, 1'b1, 2'd1);
    step();
    enable_mem = 1'b0;
    for (int k = 0; k < T - 1; k++) begin
      @(negedge clk);
      check("late ack waiting stall", 64'(stall), 64'd1);
      step();
    end
    mem_ack = 1'b1;
    mem_rdata = 16'hCAFE;
    @(negedge clk);
    check("late ack cycle stall", 64'(stall), 64'd0);
    check("late ack cycle mem_req", 64'(mem_req), 64'd1);
    step();
    mem_ack = 1'b0;
    @(negedge clk);
    check("late ack wb", 64'({wb_data, we_output, wb_valid, mem_err}), 64'({16'hCAFE, 1'b1, 1'b1, 1'b0}));
    step();

    // No ack: abort after T access cycles, held instruction captured afterwards
    drive(1'b1, 16'h0300, 16'h0000, LDST_LOAD, 3'd5, 1'b1, 2'd2);
    step();
    drive(1'b1, 16'h0055, 16'h0000, LDST_NONE, 3'd6, 1'b1, 2'd3);
    for (int k = 0; k < T; k++) begin
      @(negedge clk);
      check("timeout wait", 64'({stall, mem_req, mem_err}), 64'({1'b1, 1'b1, 1'b0}));
      step();
    end
    @(negedge clk);
    check("timeout abort", 64'({stall, mem_req, mem_err, wb_valid, wb_data}),
          64'({1'b0, 1'b0, 1'b1, 1'b0, 16'hCAFE}));
    step();
    enable_mem = 1'b0;
    @(negedge clk);
    check("after timeout no wb", 64'(wb_valid), 64'd0);
    step();
    @(negedge clk);
    check("after timeout resume", 64'({wb_valid, wb_data, destReg_addr_output, mem_err}),
          64'({1'b1, 16'h0055, 3'd6, 1'b1}));
    step();

    // Reset in the middle of an access
    drive(1'b1, 16'h0400, 16'h0000, LDST_LOAD, 3'd2, 1'b1, 2'd0);
    step();
    enable_mem = 1'b0;
    @(negedge clk);
    check("pre-reset access", 64'(mem_req), 64'd1);
    #1 reset = 1'b0;
    #1;
    check("async reset outputs", 64'(dut_vec()), 64'd0);
    step();
    reset = 1'b1;
    drive(1'b1, 16'h1234, 16'h0000, LDST_NONE, 3'd3, 1'b1, 2'd0);
    @(negedge clk);
    check("post-reset stall", 64'(stall), 64'd0);
    step();
    enable_mem = 1'b0;
    @(negedge clk);
    check("post-reset stall 2", 64'(stall), 64'd0);
    step();
    @(negedge clk);
    check("post-reset alu op", 64'(dut_vec()),
          64'({1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1234, 3'd3, 1'b1, 2'd0, 1'b1, 1'b0}));

    // Randomized traffic against the reference model
    reset = 1'b0;
    step();
    reset = 1'b1;
    p = '{16'h0000, 16'h0000, 2'd0, 3'd0, 1'b0, 2'd0};
    p_valid = 1'b0; m_busy = 1'b0; waited = 0;
    m_wb = 16'h0000; m_dest = 3'd0; m_bp = 2'd0; m_we = 1'b0; m_valid = 1'b0; m_err = 1'b0;
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(9) < 7), 16'($urandom), 16'($urandom), 2'($urandom_range(3)),
            3'($urandom_range(7)), 1'($urandom_range(1)), 2'($urandom_range(3)));
      mem_ack = 1'($urandom_range(9) < 3);
      mem_rdata = 16'($urandom);
      m_stall = m_busy && !mem_ack;
      exp_v = {m_stall, m_busy, m_busy && (p.op == LDST_STORE),
               m_busy ? p.alu : 16'h0000, m_busy ? p.data : 16'h0000,
               m_wb, m_dest, m_we, m_bp, m_valid, m_err};
      @(negedge clk);
      check($sformatf("random cycle %0d", i), 64'(dut_vec()), 64'(exp_v));
      // Model: what the edge does to the held instruction and the outputs
      m_done = p_valid && (!m_busy || mem_ack);
      m_tmo  = m_busy && !mem_ack && (waited == T - 1);
      if (m_done) begin
        m_wb = (p.op == LDST_LOAD) ? mem_rdata : p.alu;
        m_dest = p.dest; m_bp = p.bp;
        m_we = p.w && (p.op != LDST_STORE);
        m_valid = 1'b1;
      end else begin
        m_we = 1'b0; m_valid = 1'b0;
      end
      if (m_tmo) begin
        m_err = 1'b1; p_valid = 1'b0; m_busy = 1'b0;
      end else if (!m_stall) begin
        p_valid = enable_mem;
        if (enable_mem) p = '{alu_result, dataReg, ldSt_enable, destReg_addr, we, bp_input};
        m_busy = enable_mem && (ldSt_enable == LDST_LOAD || ldSt_enable == LDST_STORE);
        waited = 0;
      end else begin
        waited++;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
